// File: rtl/reg_map_pkg.sv
// Shared definitions for the parametrised host register map: access modes
// and the address decoder used by the top level.
package reg_map_pkg;

    localparam logic [1:0] MODE_RW    = 2'd0;
    localparam logic [1:0] MODE_RO    = 2'd1;
    localparam logic [1:0] MODE_W1C   = 2'd2;
    localparam logic [1:0] MODE_PULSE = 2'd3;

    typedef struct packed {
        logic       hit;
        logic [6:0] idx;
    } reg_dec_t;

    // stride must be a power of two, so alignment is a mask test and the
    // index is a shift; with constant base/stride this folds to plain logic.
    function automatic reg_dec_t reg_decode(
        input logic [31:0] addr,
        input logic [31:0] base,
        input logic [31:0] stride,
        input logic [31:0] num_regs
    );
        reg_dec_t    d;
        logic [31:0] offset;
        logic [31:0] slot;
        int          sl;
        sl = 0;
        for (int i = 0; i < 32; i++) begin
            if (stride[i]) sl = i;
        end
        offset = addr - base;
        slot   = offset >> sl;
        d.hit  = (addr >= base) && ((offset & (stride - 32'd1)) == 32'd0) && (slot < num_regs);
        d.idx  = 7'(slot);
        return d;
    endfunction

endpackage

// File: rtl/reg_map_cell.sv
// One register of the map; its behaviour (RW, RO, W1C, PULSE) is fixed at
// elaboration by MODE.
module reg_map_cell
    import reg_map_pkg::*;
#(
    parameter int              DATA_W  = 16,
    parameter logic [1:0]      MODE    = MODE_RW,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_we,
    input  logic [DATA_W/8-1:0] i_be,
    input  logic [DATA_W-1:0]   i_wdata,
    input  logic [DATA_W-1:0]   i_status,
    output logic [DATA_W-1:0]   o_q
);

    logic [DATA_W-1:0] be_mask;

    for (genvar gi = 0; gi < DATA_W / 8; gi++) begin : g_mask
        assign be_mask[gi*8 +: 8] = {8{i_be[gi]}};
    end

    if (MODE == MODE_RO) begin : g_ro
        logic unused_ro;
        assign unused_ro = ^{i_clk, i_rst_n, i_we, be_mask, i_wdata};
        assign o_q = i_status;
    end else if (MODE == MODE_W1C) begin : g_w1c
        logic [DATA_W-1:0] q_reg, q_next;
        // Status sets are ORed in after the clear, so a same-cycle set wins.
        always_comb begin
            q_next = q_reg & ~(i_we ? (i_wdata & be_mask) : '0);
            q_next = q_next | i_status;
        end
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) q_reg <= '0;
            else          q_reg <= q_next;
        end
        assign o_q = q_reg;
    end else if (MODE == MODE_PULSE) begin : g_pulse
        logic [DATA_W-1:0] q_reg, q_next;
        logic              unused_pulse;
        assign unused_pulse = ^i_status;
        always_comb begin
            q_next = RST_VAL;
            if (i_we) q_next = (i_wdata & be_mask) | (RST_VAL & ~be_mask);
        end
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) q_reg <= RST_VAL;
            else          q_reg <= q_next;
        end
        assign o_q = q_reg;
    end else begin : g_rw
        logic [DATA_W-1:0] q_reg, q_next;
        logic              unused_rw;
        assign unused_rw = ^i_status;
        always_comb begin
            q_next = q_reg;
            if (i_we) q_next = (i_wdata & be_mask) | (q_reg & ~be_mask);
        end
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) q_reg <= RST_VAL;
            else          q_reg <= q_next;
        end
        assign o_q = q_reg;
    end

endmodule

// File: rtl/reg_map_gen.sv
// Host-side register map: address decode, per-register cells, registered
// read data with a single-cycle ack/err response and write strobes.
module reg_map_gen
    import reg_map_pkg::*;
#(
    parameter int                           DATA_W    = 16,
    parameter int                           NUM_REGS  = 9,
    parameter int                           ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]            BASE_ADDR = '0,
    parameter int                           STRIDE    = 2,
    parameter logic [2*NUM_REGS-1:0]        MODE      = '0,
    parameter logic [NUM_REGS*DATA_W-1:0]   RST_VAL   = '0
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_req,
    input  logic                         i_wen,
    input  logic [ADDR_W-1:0]            i_addr,
    input  logic [DATA_W-1:0]            i_wdata,
    input  logic [DATA_W/8-1:0]          i_be,
    output logic                         o_ack,
    output logic                         o_err,
    output logic [DATA_W-1:0]            o_q,
    output logic [NUM_REGS*DATA_W-1:0]   o_regs,
    input  logic [NUM_REGS*DATA_W-1:0]   i_status,
    output logic [NUM_REGS-1:0]          o_wstb
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    reg_dec_t          dec;
    logic              hit;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] reg_val [NUM_REGS];
    logic [DATA_W-1:0] rdata;
    logic [NUM_REGS-1:0] wr_en;

    logic                ack_reg, err_reg;
    logic [DATA_W-1:0]   q_reg;
    logic [NUM_REGS-1:0] wstb_reg;

    assign dec = reg_decode(32'(i_addr), 32'(BASE_ADDR), 32'(STRIDE), 32'(NUM_REGS));
    assign hit = dec.hit;
    assign idx = IDX_W'(dec.idx);

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
        assign wr_en[gi] = i_req & i_wen & hit & (idx == IDX_W'(gi));

        reg_map_cell #(
            .DATA_W  (DATA_W),
            .MODE    (MODE[2*gi +: 2]),
            .RST_VAL (RST_VAL[gi*DATA_W +: DATA_W])
        ) u_cell (
            .i_clk    (i_clk),
            .i_rst_n  (i_rst_n),
            .i_we     (wr_en[gi]),
            .i_be     (i_be),
            .i_wdata  (i_wdata),
            .i_status (i_status[gi*DATA_W +: DATA_W]),
            .o_q      (reg_val[gi])
        );

        assign o_regs[gi*DATA_W +: DATA_W] = reg_val[gi];
    end

    // Misses read as zero, so the error response carries o_q = 0.
    assign rdata = hit ? reg_val[idx] : '0;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ack_reg  <= 1'b0;
            err_reg  <= 1'b0;
            q_reg    <= '0;
            wstb_reg <= '0;
        end else begin
            ack_reg  <= i_req;
            err_reg  <= i_req & ~hit;
            wstb_reg <= wr_en;
            if (i_req && !i_wen) q_reg <= rdata;
        end
    end

    assign o_ack  = ack_reg;
    assign o_err  = err_reg;
    assign o_q    = q_reg;
    assign o_wstb = wstb_reg;

endmodule

// File: tb/tb_reg_map_gen.sv
// Scoreboard bench for reg_map_gen: a 9x16 map with RO/W1C/PULSE registers
// and a 4x32 map at base 0x100 with stride 4 for bursts and mid-access reset.
module tb_reg_map_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [17:0]  MODE_A = 18'b11_000000000000_10_01;
    localparam logic [127:0] RST_B  = {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000};

    logic         a_rst_n, a_req, a_wen, a_ack, a_err;
    logic [15:0]  a_addr, a_wdata, a_q;
    logic [1:0]   a_be;
    logic [143:0] a_regs, a_status;
    logic [8:0]   a_wstb;

    logic         b_rst_n, b_req, b_wen, b_ack, b_err;
    logic [15:0]  b_addr;
    logic [31:0]  b_wdata, b_q;
    logic [3:0]   b_be, b_wstb;
    logic [127:0] b_regs, b_status;

    reg_map_gen #(
        .DATA_W(16), .NUM_REGS(9), .ADDR_W(16), .BASE_ADDR(16'h0000), .STRIDE(2),
        .MODE(MODE_A), .RST_VAL('0)
    ) u_dut_a (
        .i_clk(clk), .i_rst_n(a_rst_n), .i_req(a_req), .i_wen(a_wen), .i_addr(a_addr),
        .i_wdata(a_wdata), .i_be(a_be), .o_ack(a_ack), .o_err(a_err), .o_q(a_q),
        .o_regs(a_regs), .i_status(a_status), .o_wstb(a_wstb)
    );

    reg_map_gen #(
        .DATA_W(32), .NUM_REGS(4), .ADDR_W(16), .BASE_ADDR(16'h0100), .STRIDE(4),
        .MODE('0), .RST_VAL(RST_B)
    ) u_dut_b (
        .i_clk(clk), .i_rst_n(b_rst_n), .i_req(b_req), .i_wen(b_wen), .i_addr(b_addr),
        .i_wdata(b_wdata), .i_be(b_be), .o_ack(b_ack), .o_err(b_err), .o_q(b_q),
        .o_regs(b_regs), .i_status(b_status), .o_wstb(b_wstb)
    );

    typedef struct {
        logic        err;
        logic [31:0] q;
        logic        chk_q;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Drives one request on map A for one cycle; returns in the ack cycle.
    task automatic a_drive(input logic wen, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be);
        a_req = 1'b1; a_wen = wen; a_addr = addr; a_wdata = wdata; a_be = be;
        @(negedge clk);
        a_req = 1'b0; a_wen = 1'b0;
    endtask

    task automatic test_reset();
        a_rst_n = 1'b0; b_rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({a_ack, a_err, a_q, a_wstb} !== 27'd0) begin
            n_bad++;
            $display("FAIL reset_outs: ack=%b err=%b q=%h wstb=%b, want all 0", a_ack, a_err, a_q, a_wstb);
        end else $display("pass reset_outs");
        n_cmp++;
        if (a_regs !== 144'd0) begin
            n_bad++;
            $display("FAIL reset_regs: regs=%h, want 0", a_regs);
        end else $display("pass reset_regs");
        a_rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 9; k++) begin
            sb.push_back('{1'b0, 32'h0, 1'b1});
            a_drive(1'b0, 16'(2 * k), 16'h0, 2'b00);
            e = sb.pop_front();
            n_cmp++;
            if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q) begin
                n_bad++;
                $display("FAIL rd_reset_reg%0d: ack=%b err=%b q=%h, want ack=1 err=%b q=%h", k, a_ack, a_err, a_q, e.err, e.q);
            end else $display("pass rd_reset_reg%0d q=%h", k, a_q);
        end
        @(negedge clk);
        n_cmp++;
        if (a_ack !== 1'b0 || a_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ack_single_cycle: ack=%b err=%b, want 0 0", a_ack, a_err);
        end else $display("pass ack_single_cycle");
        for (int k = 0; k < 2; k++) begin
            logic [15:0] bad_addr;
            bad_addr = (k == 0) ? 16'h0012 : 16'h0003;
            sb.push_back('{1'b1, 32'h0, 1'b1});
            a_drive(1'b0, bad_addr, 16'h0, 2'b00);
            e = sb.pop_front();
            n_cmp++;
            if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q) begin
                n_bad++;
                $display("FAIL rd_unmapped_%h: ack=%b err=%b q=%h, want ack=1 err=1 q=0", bad_addr, a_ack, a_err, a_q);
            end else $display("pass rd_unmapped_%h", bad_addr);
        end
    endtask

    task automatic test_rw_be();
        logic [15:0] wd [2];
        logic [1:0]  wb [2];
        wd[0] = 16'h1234; wb[0] = 2'b11;
        wd[1] = 16'hAB00; wb[1] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            sb.push_back('{1'b0, 32'h0, 1'b0});
            a_drive(1'b1, 16'h0004, wd[k], wb[k]);
            e = sb.pop_front();
            n_cmp++;
            if (a_ack !== 1'b1 || a_err !== e.err || a_wstb !== 9'b0_0000_0100) begin
                n_bad++;
                $display("FAIL wr_rw_%0d: ack=%b err=%b wstb=%b, want ack=1 err=0 wstb=000000100", k, a_ack, a_err, a_wstb);
            end else $display("pass wr_rw_%0d data=%h be=%b", k, wd[k], wb[k]);
        end
        n_cmp++;
        if (a_regs[32 +: 16] !== 16'hAB34) begin
            n_bad++;
            $display("FAIL rw_regs: reg2=%h, want ab34", a_regs[32 +: 16]);
        end else $display("pass rw_regs");
        sb.push_back('{1'b0, 32'h0000_AB34, 1'b1});
        a_drive(1'b0, 16'h0004, 16'h0, 2'b00);
        e = sb.pop_front();
        n_cmp++;
        if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q) begin
            n_bad++;
            $display("FAIL rd_rw: ack=%b err=%b q=%h, want ack=1 err=0 q=%h", a_ack, a_err, a_q, e.q);
        end else $display("pass rd_rw q=%h", a_q);
    endtask

    task automatic test_w1c();
        // step: 0 set-by-status, 1 clear, 2 set+clear same cycle,
        //       3 clear, 4 read while set pending, 5 read after set
        logic [15:0] want [6];
        want[0] = 16'h0008; want[1] = 16'h0000; want[2] = 16'h0008;
        want[3] = 16'h0000; want[4] = 16'h0000; want[5] = 16'h0008;
        a_status[19] = 1'b1;
        @(negedge clk);
        a_status[19] = 1'b0;
        for (int s = 0; s < 6; s++) begin
            if (s == 1 || s == 2 || s == 3) begin
                if (s == 2) a_status[19] = 1'b1;
                sb.push_back('{1'b0, 32'h0, 1'b0});
                a_drive(1'b1, 16'h0002, 16'h0008, 2'b11);
                a_status[19] = 1'b0;
                e = sb.pop_front();
                n_cmp++;
                if (a_ack !== 1'b1 || a_err !== e.err) begin
                    n_bad++;
                    $display("FAIL wr_w1c_s%0d: ack=%b err=%b, want 1 0", s, a_ack, a_err);
                end else $display("pass wr_w1c_s%0d", s);
            end
            if (s == 4) a_status[19] = 1'b1;
            sb.push_back('{1'b0, 32'(want[s]), 1'b1});
            a_drive(1'b0, 16'h0002, 16'h0, 2'b00);
            a_status[19] = 1'b0;
            e = sb.pop_front();
            n_cmp++;
            if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q) begin
                n_bad++;
                $display("FAIL rd_w1c_s%0d: ack=%b err=%b q=%h, want ack=1 err=0 q=%h", s, a_ack, a_err, a_q, e.q);
            end else $display("pass rd_w1c_s%0d q=%h", s, a_q);
        end
    endtask

    task automatic test_pulse();
        sb.push_back('{1'b0, 32'h0, 1'b0});
        a_drive(1'b1, 16'h0010, 16'h00FF, 2'b11);
        e = sb.pop_front();
        n_cmp++;
        if (a_ack !== 1'b1 || a_err !== e.err || a_regs[128 +: 16] !== 16'h00FF || a_wstb !== 9'h100) begin
            n_bad++;
            $display("FAIL pulse_high: ack=%b err=%b reg8=%h wstb=%b, want 1 0 00ff 100000000", a_ack, a_err, a_regs[128 +: 16], a_wstb);
        end else $display("pass pulse_high reg8=%h", a_regs[128 +: 16]);
        @(negedge clk);
        n_cmp++;
        if (a_regs[128 +: 16] !== 16'h0000) begin
            n_bad++;
            $display("FAIL pulse_return: reg8=%h, want 0000", a_regs[128 +: 16]);
        end else $display("pass pulse_return");
    endtask

    task automatic test_ro();
        logic [143:0] exp_regs;
        a_status[15:0] = 16'h5A5A;
        #1;
        n_cmp++;
        if (a_regs[15:0] !== 16'h5A5A) begin
            n_bad++;
            $display("FAIL ro_passthru: reg0=%h, want 5a5a", a_regs[15:0]);
        end else $display("pass ro_passthru");
        @(negedge clk);
        sb.push_back('{1'b0, 32'h0, 1'b0});
        a_drive(1'b1, 16'h0000, 16'hFFFF, 2'b11);
        e = sb.pop_front();
        n_cmp++;
        if (a_ack !== 1'b1 || a_err !== e.err || a_wstb !== 9'h001) begin
            n_bad++;
            $display("FAIL wr_ro: ack=%b err=%b wstb=%b, want 1 0 000000001", a_ack, a_err, a_wstb);
        end else $display("pass wr_ro");
        sb.push_back('{1'b0, 32'h0000_5A5A, 1'b1});
        a_drive(1'b0, 16'h0000, 16'h0, 2'b00);
        e = sb.pop_front();
        n_cmp++;
        if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q) begin
            n_bad++;
            $display("FAIL rd_ro: ack=%b err=%b q=%h, want ack=1 err=0 q=5a5a", a_ack, a_err, a_q);
        end else $display("pass rd_ro q=%h", a_q);
        sb.push_back('{1'b1, 32'h0000_5A5A, 1'b1});
        a_drive(1'b1, 16'h0012, 16'hBEEF, 2'b11);
        e = sb.pop_front();
        exp_regs = '0;
        exp_regs[15:0]  = 16'h5A5A;
        exp_regs[31:16] = 16'h0008;
        exp_regs[47:32] = 16'hAB34;
        n_cmp++;
        if (a_ack !== 1'b1 || a_err !== e.err || 32'(a_q) !== e.q || a_wstb !== 9'h000 || a_regs !== exp_regs) begin
            n_bad++;
            $display("FAIL wr_unmapped: ack=%b err=%b q=%h wstb=%b regs=%h", a_ack, a_err, a_q, a_wstb, a_regs);
        end else $display("pass wr_unmapped");
        @(negedge clk);
        n_cmp++;
        if (a_ack !== 1'b0 || a_err !== 1'b0 || a_q !== 16'h5A5A) begin
            n_bad++;
            $display("FAIL idle_hold: ack=%b err=%b q=%h, want 0 0 5a5a", a_ack, a_err, a_q);
        end else $display("pass idle_hold");
    endtask

    task automatic test_back_to_back();
        b_rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            sb.push_back('{1'b0, 32'h0, 1'b0});
            b_req = 1'b1; b_wen = 1'b1; b_addr = 16'(16'h0100 + 4 * k);
            b_wdata = {16'hC0DE, 8'(k), 8'h5A}; b_be = 4'hF;
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (b_ack !== 1'b1 || b_err !== e.err || b_wstb !== 4'(1 << k)) begin
                n_bad++;
                $display("FAIL b2b_wr%0d: ack=%b err=%b wstb=%b", k, b_ack, b_err, b_wstb);
            end else $display("pass b2b_wr%0d addr=%h", k, 16'h0100 + 4 * k);
        end
        for (int k = 0; k < 7; k++) begin
            logic [15:0] ra;
            logic        bad;
            bad = (k >= 4);
            ra  = (k < 4) ? 16'(16'h0100 + 4 * k) : (k == 4) ? 16'h0110 : (k == 5) ? 16'h0102 : 16'h00FC;
            sb.push_back('{bad, bad ? 32'h0 : {16'hC0DE, 8'(k), 8'h5A}, 1'b1});
            b_req = 1'b1; b_wen = 1'b0; b_addr = ra;
            @(negedge clk);
            e = sb.pop_front();
            n_cmp++;
            if (b_ack !== 1'b1 || b_err !== e.err || b_q !== e.q) begin
                n_bad++;
                $display("FAIL b2b_rd_%h: ack=%b err=%b q=%h, want ack=1 err=%b q=%h", ra, b_ack, b_err, b_q, e.err, e.q);
            end else $display("pass b2b_rd_%h q=%h err=%b", ra, b_q, b_err);
        end
        b_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (b_ack !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_idle: ack=%b, want 0", b_ack);
        end else $display("pass b2b_idle");
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) begin
            sb.push_back('{1'b0, 32'h0, 1'b0});
            b_req = 1'b1; b_wen = 1'b1; b_addr = 16'(16'h0100 + 4 * k);
            b_wdata = 32'h7700_0000 + 32'(k); b_be = 4'hF;
            if (k == 2) begin
                @(posedge clk);
                #1;
                b_rst_n = 1'b0; b_req = 1'b0; b_wen = 1'b0;
                sb.delete();
            end else begin
                @(negedge clk);
                e = sb.pop_front();
                n_cmp++;
                if (b_ack !== 1'b1 || b_err !== e.err) begin
                    n_bad++;
                    $display("FAIL rst_mid_wr%0d: ack=%b err=%b, want 1 0", k, b_ack, b_err);
                end else $display("pass rst_mid_wr%0d", k);
            end
        end
        @(negedge clk);
        n_cmp++;
        if (b_ack !== 1'b0 || b_regs !== RST_B) begin
            n_bad++;
            $display("FAIL rst_mid_drop: ack=%b regs=%h, want 0 %h", b_ack, b_regs, RST_B);
        end else $display("pass rst_mid_drop");
        b_rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_cmp++;
            if (b_ack !== 1'b0) begin
                n_bad++;
                $display("FAIL rst_mid_noack%0d: ack=%b, want 0", k, b_ack);
            end else $display("pass rst_mid_noack%0d", k);
        end
        n_cmp++;
        if (b_regs !== RST_B) begin
            n_bad++;
            $display("FAIL rst_mid_regs: regs=%h, want %h", b_regs, RST_B);
        end else $display("pass rst_mid_regs");
        sb.push_back('{1'b0, 32'h3333_0002, 1'b1});
        b_req = 1'b1; b_wen = 1'b0; b_addr = 16'h0108;
        @(negedge clk);
        b_req = 1'b0;
        e = sb.pop_front();
        n_cmp++;
        if (b_ack !== 1'b1 || b_err !== e.err || b_q !== e.q) begin
            n_bad++;
            $display("FAIL rst_mid_rd: ack=%b err=%b q=%h, want 1 0 %h", b_ack, b_err, b_q, e.q);
        end else $display("pass rst_mid_rd q=%h", b_q);
    endtask

    initial begin
        a_rst_n = 1'b0; a_req = 1'b0; a_wen = 1'b0; a_addr = '0; a_wdata = '0; a_be = '0; a_status = '0;
        b_rst_n = 1'b0; b_req = 1'b0; b_wen = 1'b0; b_addr = '0; b_wdata = '0; b_be = '0; b_status = '0;
        @(negedge clk);
        test_reset();
        test_rw_be();
        test_w1c();
        test_pulse();
        test_ro();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
